quadrature_counter: RTL and testbench
=====================================

QUADRATURE_COUNTER -- requirements
Module: quadrature_counter

Interface
REQ-001 Parameter WIDTH, default 8: bit width of count.
REQ-002 Parameter MAX_VAL, default 255: upper count bound, SHALL satisfy 0 < MAX_VAL <= 2^WIDTH-1.
REQ-003 Parameter WRAP, default 1: 1 = modular count, 0 = saturating count.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset; low = reset asserted.
REQ-006 a  input  1  encoder phase A, debounced, asynchronous to clk.
REQ-007 b  input  1  encoder phase B, debounced, asynchronous to clk.
REQ-008 en  input  1  count enable, synchronous.
REQ-009 clear  input  1  synchronous clear of count and sub-step accumulator.
REQ-010 count  output  WIDTH  current registered count value.
REQ-011 step_up  output  1  one-cycle pulse on each increment event.
REQ-012 step_dn  output  1  one-cycle pulse on each decrement event.
REQ-013 err  output  1  one-cycle pulse on illegal phase transition.

Function
REQ-014 a and b SHALL each pass through a 2-flop synchronizer; decoding uses only synchronized values.
REQ-015 Block SHALL hold prev = last synchronized {a,b} and a primed flag; the first synchronized sample after reset loads prev, sets primed, and generates no event.
REQ-016 Forward transitions {a,b}: 00->01, 01->11, 11->10, 10->00 SHALL add +1 to a signed sub-step accumulator acc (range -3..+3).
REQ-017 Reverse transitions (inverse of REQ-016) SHALL add -1 to acc.
REQ-018 No change in {a,b}: acc unchanged, no pulse.
REQ-019 Both bits changing in one sample (00<->11, 01<->10): err pulses 1 cycle, acc cleared to 0, count unchanged.
REQ-020 acc reaching +4: acc cleared, increment event; reaching -4: acc cleared, decrement event (one event per full detent cycle of 4 transitions).
REQ-021 Increment: WRAP=1 count = (count==MAX_VAL) ? 0 : count+1; WRAP=0 count = min(count+1, MAX_VAL).
REQ-022 Decrement: WRAP=1 count = (count==0) ? MAX_VAL : count-1; WRAP=0 count = max(count-1, 0).
REQ-023 step_up/step_dn SHALL pulse on every increment/decrement event, including when saturation leaves count unchanged.
REQ-024 Latency: pin edge to count/pulse update SHALL be exactly 3 clk cycles (2 sync + 1 decode register).
REQ-025 en low: prev keeps tracking, acc forced to 0, no step pulses, count held; err still reported.
REQ-026 clear high: count <= 0, acc <= 0, step pulses suppressed that cycle; clear has priority over any concurrent event; prev still updated.
REQ-027 Outputs count, step_up, step_dn, err SHALL all be registered.
REQ-028 step_up and step_dn SHALL never be high in the same cycle.

Reset
REQ-029 rst low SHALL immediately and asynchronously force count=0, acc=0, step_up=0, step_dn=0, err=0, primed=0, synchronizer flops=0.
REQ-030 Reset asserted mid-detent (acc != 0) SHALL discard the partial detent; after release, counting resumes only after priming per REQ-015.
REQ-031 No output SHALL pulse in the cycle rst deasserts.

Verification
REQ-032 Reset release with a=b=1 held, no further activity -> count=0, no pulses, no err (priming, no spurious event).
REQ-033 From 00, drive 3 forward detents (12 transitions, each held >=4 clks) -> count=3, three step_up pulses each 3 clks after the 4th transition of its detent.
REQ-034 WRAP=1, MAX_VAL=9, count=9, one forward detent -> count=0, step_up pulses; one reverse detent -> count=9, step_dn pulses.
REQ-035 WRAP=0, count=0, one reverse detent -> count stays 0, step_dn pulses once; at count=MAX_VAL forward detent -> count stays MAX_VAL.
REQ-036 Two forward transitions, then 01->10 jump, then 4 forward transitions -> err pulses once, count increments by exactly 1.
REQ-037 clear asserted in the same cycle an increment event is due, count=5 -> count=0, no step_up pulse; subsequent full detent -> count=1.

Source files
------------

// File: rtl/quadrature_counter.sv
// Quadrature encoder decoder: synchronizes phases A/B, accumulates sub-steps
// and emits one count step per full detent (four legal transitions).
module quadrature_counter #(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = 255,
  parameter int WRAP    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             en,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             step_up,
  output logic             step_dn,
  output logic             err
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

  logic [1:0]       pins;
  logic [1:0]       sync1_reg;
  logic [1:0]       sync2_reg;
  logic [1:0]       vld_reg;
  logic [1:0]       prev_reg, prev_next;
  logic             primed_reg, primed_next;
  logic signed [2:0] acc_reg, acc_next;
  logic [WIDTH-1:0] count_next;
  logic             up_next, dn_next, err_next;
  logic             inc, dec;
  logic [1:0]       delta;

  assign pins = {a, b};

  // Position of a phase pair along the forward Gray sequence 00,01,11,10.
  function automatic logic [1:0] phase_idx(input logic [1:0] ab);
    case (ab)
      2'b00:   phase_idx = 2'd0;
      2'b01:   phase_idx = 2'd1;
      2'b11:   phase_idx = 2'd2;
      default: phase_idx = 2'd3;
    endcase
  endfunction

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sync1_reg[gi] <= 1'b0;
          sync2_reg[gi] <= 1'b0;
        end else begin
          sync1_reg[gi] <= pins[gi];
          sync2_reg[gi] <= sync1_reg[gi];
        end
      end
    end
  endgenerate

  // vld_reg[1] marks that sync2_reg holds a real pin sample, not reset fill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vld_reg <= 2'b00;
    else      vld_reg <= {vld_reg[0], 1'b1};
  end

  assign delta = phase_idx(sync2_reg) - phase_idx(prev_reg);

  always_comb begin
    prev_next   = prev_reg;
    primed_next = primed_reg;
    acc_next    = acc_reg;
    count_next  = count;
    err_next    = 1'b0;
    inc         = 1'b0;
    dec         = 1'b0;

    if (!primed_reg) begin
      if (vld_reg[1]) begin
        prev_next   = sync2_reg;
        primed_next = 1'b1;
      end
    end else begin
      prev_next = sync2_reg;
      case (delta)
        2'd1: begin
          if (acc_reg == 3'sd3) begin
            acc_next = 3'sd0;
            inc      = 1'b1;
          end else begin
            acc_next = acc_reg + 3'sd1;
          end
        end
        2'd3: begin
          if (acc_reg == -3'sd3) begin
            acc_next = 3'sd0;
            dec      = 1'b1;
          end else begin
            acc_next = acc_reg - 3'sd1;
          end
        end
        2'd2: begin
          err_next = 1'b1;
          acc_next = 3'sd0;
        end
        default: ;
      endcase
    end

    if (!en) begin
      acc_next = 3'sd0;
      inc      = 1'b0;
      dec      = 1'b0;
    end

    if (clear) begin
      acc_next   = 3'sd0;
      count_next = '0;
      inc        = 1'b0;
      dec        = 1'b0;
    end else if (inc) begin
      if (count == MAX_C) count_next = (WRAP != 0) ? '0 : count;
      else                count_next = count + WIDTH'(1);
    end else if (dec) begin
      if (count == '0) count_next = (WRAP != 0) ? MAX_C : count;
      else             count_next = count - WIDTH'(1);
    end

    up_next = inc;
    dn_next = dec;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_reg   <= 2'b00;
      primed_reg <= 1'b0;
      acc_reg    <= 3'sd0;
      count      <= '0;
      step_up    <= 1'b0;
      step_dn    <= 1'b0;
      err        <= 1'b0;
    end else begin
      prev_reg   <= prev_next;
      primed_reg <= primed_next;
      acc_reg    <= acc_next;
      count      <= count_next;
      step_up    <= up_next;
      step_dn    <= dn_next;
      err        <= err_next;
    end
  end

endmodule

// File: tb/tb_quadrature_counter.sv
// Directed bench: a wrapping and a saturating counter (MAX_VAL=9) share stimulus.
module tb_quadrature_counter;

  logic       clk;
  logic       rst;
  logic       a, b, en, clear;
  logic [3:0] count_w, count_s;
  logic       up_w, dn_w, err_w, up_s, dn_s, err_s;
  logic [5:0] pv;
  logic [1:0] ab_cur;
  int         n_checks;
  int         n_fail;

  assign pv = {up_w, dn_w, up_s, dn_s, err_w, err_s};

  quadrature_counter #(.WIDTH(4), .MAX_VAL(9), .WRAP(1)) dut_w (
    .clk(clk), .rst(rst), .a(a), .b(b), .en(en), .clear(clear),
    .count(count_w), .step_up(up_w), .step_dn(dn_w), .err(err_w)
  );

  quadrature_counter #(.WIDTH(4), .MAX_VAL(9), .WRAP(0)) dut_s (
    .clk(clk), .rst(rst), .a(a), .b(b), .en(en), .clear(clear),
    .count(count_s), .step_up(up_s), .step_dn(dn_s), .err(err_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [1:0] fwd_of(input logic [1:0] x);
    case (x)
      2'b00:   fwd_of = 2'b01;
      2'b01:   fwd_of = 2'b11;
      2'b11:   fwd_of = 2'b10;
      default: fwd_of = 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] rev_of(input logic [1:0] x);
    case (x)
      2'b00:   rev_of = 2'b10;
      2'b10:   rev_of = 2'b11;
      2'b11:   rev_of = 2'b01;
      default: rev_of = 2'b00;
    endcase
  endfunction

  // Drive one phase pair for 4 clocks; o = pulses 3 clocks later, s = pulses at any other cycle.
  task automatic move(input logic [1:0] ab, input int clr_cycle,
                      output logic [5:0] o, output logic [5:0] s);
    a = ab[1];
    b = ab[0];
    ab_cur = ab;
    o = '0;
    s = '0;
    for (int c = 1; c <= 4; c++) begin
      clear = (c == clr_cycle);
      @(posedge clk);
      #1;
      if (c == 3) o = pv;
      else        s = s | pv;
      @(negedge clk);
    end
    clear = 1'b0;
  endtask

  task automatic detent(input logic fwd, input int clr4,
                        output logic [5:0] o, output logic [5:0] s);
    logic [5:0] mo, ms;
    s = '0;
    o = '0;
    for (int k = 0; k < 4; k++) begin
      move(fwd ? fwd_of(ab_cur) : rev_of(ab_cur), (k == 3) ? clr4 : 0, mo, ms);
      if (k == 3) o = mo;
      else        s = s | mo;
      s = s | ms;
    end
  endtask

  task automatic idle(input int n, output logic [5:0] s);
    s = '0;
    repeat (n) begin
      @(posedge clk);
      #1;
      s = s | pv;
      @(negedge clk);
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] s;
    rst = 1'b0; en = 1'b1; clear = 1'b0; a = 1'b1; b = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({count_w, count_s} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_count: got %h/%h want 0/0", count_w, count_s);
    end
    n_checks++;
    if (pv !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_pulses: got %b want 000000", pv);
    end
    rst = 1'b1;
    ab_cur = 2'b11;
    idle(8, s);
    n_checks++;
    if (s !== 6'b0) begin
      n_fail++;
      $display("FAIL prime_no_event: got %b want 000000", s);
    end
    n_checks++;
    if ({count_w, count_s} !== 8'h00) begin
      n_fail++;
      $display("FAIL prime_count: got %h/%h want 0/0", count_w, count_s);
    end
    $display("test_reset done: count %0d/%0d", count_w, count_s);
  endtask

  task automatic test_forward();
    logic [5:0] o, s;
    rst = 1'b0; a = 1'b0; b = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ab_cur = 2'b00;
    idle(6, s);
    for (int d = 0; d < 3; d++) begin
      detent(1'b1, 0, o, s);
      n_checks++;
      if (o !== 6'b101000 || s !== 6'b0) begin
        n_fail++;
        $display("FAIL fwd_pulse%0d: got o=%b s=%b want o=101000 s=000000", d, o, s);
      end
      n_checks++;
      if (count_w !== 4'(d + 1) || count_s !== 4'(d + 1)) begin
        n_fail++;
        $display("FAIL fwd_count%0d: got %0d/%0d want %0d", d, count_w, count_s, d + 1);
      end
      $display("fwd detent %0d: count %0d/%0d", d, count_w, count_s);
    end
  endtask

  task automatic test_wrap();
    logic [5:0] o, s;
    for (int d = 0; d < 6; d++) begin
      detent(1'b1, 0, o, s);
      n_checks++;
      if (o !== 6'b101000 || s !== 6'b0 || count_w !== 4'(4 + d) || count_s !== 4'(4 + d)) begin
        n_fail++;
        $display("FAIL climb%0d: got o=%b s=%b cnt=%0d/%0d want 101000 000000 %0d",
                 d, o, s, count_w, count_s, 4 + d);
      end
    end
    detent(1'b1, 0, o, s);
    n_checks++;
    if (o !== 6'b101000 || s !== 6'b0) begin
      n_fail++;
      $display("FAIL wrap_up_pulse: got o=%b s=%b want 101000 000000", o, s);
    end
    n_checks++;
    if (count_w !== 4'd0 || count_s !== 4'd9) begin
      n_fail++;
      $display("FAIL wrap_up_count: got %0d/%0d want 0/9", count_w, count_s);
    end
    $display("wrap up: count %0d/%0d", count_w, count_s);
    detent(1'b0, 0, o, s);
    n_checks++;
    if (o !== 6'b010100 || s !== 6'b0) begin
      n_fail++;
      $display("FAIL wrap_dn_pulse: got o=%b s=%b want 010100 000000", o, s);
    end
    n_checks++;
    if (count_w !== 4'd9 || count_s !== 4'd8) begin
      n_fail++;
      $display("FAIL wrap_dn_count: got %0d/%0d want 9/8", count_w, count_s);
    end
    $display("wrap down: count %0d/%0d", count_w, count_s);
  endtask

  task automatic test_saturate();
    logic [5:0] o, s;
    pulse_clear();
    n_checks++;
    if (count_w !== 4'd0 || count_s !== 4'd0) begin
      n_fail++;
      $display("FAIL clear_count: got %0d/%0d want 0/0", count_w, count_s);
    end
    detent(1'b0, 0, o, s);
    n_checks++;
    if (o !== 6'b010100 || s !== 6'b0) begin
      n_fail++;
      $display("FAIL sat_dn_pulse: got o=%b s=%b want 010100 000000", o, s);
    end
    n_checks++;
    if (count_w !== 4'd9 || count_s !== 4'd0) begin
      n_fail++;
      $display("FAIL sat_dn_count: got %0d/%0d want 9/0", count_w, count_s);
    end
    $display("saturate down: count %0d/%0d", count_w, count_s);
  endtask

  task automatic test_illegal();
    logic [5:0] o, s, acc_s;
    acc_s = '0;
    move(2'b10, 0, o, s);
    acc_s = acc_s | o | s;
    pulse_clear();
    move(2'b00, 0, o, s);
    acc_s = acc_s | o | s;
    move(2'b01, 0, o, s);
    acc_s = acc_s | o | s;
    move(2'b10, 0, o, s);
    acc_s = acc_s | s;
    n_checks++;
    if (o !== 6'b000011) begin
      n_fail++;
      $display("FAIL err_pulse: got %b want 000011", o);
    end
    detent(1'b1, 0, o, s);
    acc_s = acc_s | s;
    n_checks++;
    if (o !== 6'b101000 || acc_s !== 6'b0) begin
      n_fail++;
      $display("FAIL err_resume: got o=%b stray=%b want 101000 000000", o, acc_s);
    end
    n_checks++;
    if (count_w !== 4'd1 || count_s !== 4'd1) begin
      n_fail++;
      $display("FAIL err_count: got %0d/%0d want 1/1", count_w, count_s);
    end
    $display("illegal jump: count %0d/%0d", count_w, count_s);
  endtask

  task automatic test_clear_priority();
    logic [5:0] o, s;
    for (int d = 0; d < 4; d++) detent(1'b1, 0, o, s);
    n_checks++;
    if (count_w !== 4'd5 || count_s !== 4'd5) begin
      n_fail++;
      $display("FAIL pre_clear_count: got %0d/%0d want 5/5", count_w, count_s);
    end
    detent(1'b1, 3, o, s);
    n_checks++;
    if (o !== 6'b0 || s !== 6'b0 || count_w !== 4'd0 || count_s !== 4'd0) begin
      n_fail++;
      $display("FAIL clear_prio: got o=%b s=%b cnt=%0d/%0d want 000000 000000 0/0",
               o, s, count_w, count_s);
    end
    detent(1'b1, 0, o, s);
    n_checks++;
    if (o !== 6'b101000 || count_w !== 4'd1 || count_s !== 4'd1) begin
      n_fail++;
      $display("FAIL after_clear: got o=%b cnt=%0d/%0d want 101000 1/1", o, count_w, count_s);
    end
    $display("clear priority: count %0d/%0d", count_w, count_s);
  endtask

  task automatic test_enable();
    logic [5:0] o, s, acc_s;
    acc_s = '0;
    en = 1'b0;
    detent(1'b1, 0, o, s);
    n_checks++;
    if (o !== 6'b0 || s !== 6'b0 || count_w !== 4'd1 || count_s !== 4'd1) begin
      n_fail++;
      $display("FAIL en_hold: got o=%b s=%b cnt=%0d/%0d want 000000 000000 1/1",
               o, s, count_w, count_s);
    end
    move(2'b01, 0, o, s);
    n_checks++;
    if (o !== 6'b000011) begin
      n_fail++;
      $display("FAIL en_err: got %b want 000011", o);
    end
    en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      move(fwd_of(ab_cur), 0, o, s);
      acc_s = acc_s | o | s;
    end
    en = 1'b0;
    idle(2, s);
    acc_s = acc_s | s;
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      move(fwd_of(ab_cur), 0, o, s);
      acc_s = acc_s | o | s;
    end
    move(fwd_of(ab_cur), 0, o, s);
    acc_s = acc_s | s;
    n_checks++;
    if (acc_s !== 6'b0 || o !== 6'b101000) begin
      n_fail++;
      $display("FAIL en_acc_flush: got o=%b stray=%b want 101000 000000", o, acc_s);
    end
    n_checks++;
    if (count_w !== 4'd2 || count_s !== 4'd2) begin
      n_fail++;
      $display("FAIL en_count: got %0d/%0d want 2/2", count_w, count_s);
    end
    $display("enable: count %0d/%0d", count_w, count_s);
  endtask

  task automatic test_reset_mid();
    logic [5:0] o, s, acc_s;
    acc_s = '0;
    move(fwd_of(ab_cur), 0, o, s);
    move(fwd_of(ab_cur), 0, o, s);
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (count_w !== 4'd0 || count_s !== 4'd0 || pv !== 6'b0) begin
      n_fail++;
      $display("FAIL async_reset: got cnt=%0d/%0d pv=%b want 0/0 000000", count_w, count_s, pv);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(6, s);
    acc_s = acc_s | s;
    for (int k = 0; k < 3; k++) begin
      move(fwd_of(ab_cur), 0, o, s);
      acc_s = acc_s | o | s;
    end
    move(fwd_of(ab_cur), 0, o, s);
    acc_s = acc_s | s;
    n_checks++;
    if (acc_s !== 6'b0 || o !== 6'b101000) begin
      n_fail++;
      $display("FAIL partial_discard: got o=%b stray=%b want 101000 000000", o, acc_s);
    end
    n_checks++;
    if (count_w !== 4'd1 || count_s !== 4'd1) begin
      n_fail++;
      $display("FAIL post_reset_count: got %0d/%0d want 1/1", count_w, count_s);
    end
    $display("mid-detent reset: count %0d/%0d", count_w, count_s);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0; a = 1'b0; b = 1'b0; en = 1'b1; clear = 1'b0;
    ab_cur = 2'b00;
    test_reset();
    test_forward();
    test_wrap();
    test_saturate();
    test_illegal();
    test_clear_priority();
    test_enable();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
